commit_trace_checker: RTL
=========================

Name: commit_trace_checker

Overview:
- Synthesisable lockstep checker that compares the core's retired-instruction stream against a preloaded golden commit trace.
- Generalises the per-cycle PC/register/DMEM golden compare into a per-commit, parametrised block.
- Instantiated beside RISCV_Single_Cycle, or later pipelined cores, in simulation and FPGA bring-up.
- Reports mismatch counts, first-failure diagnostics and a commit-gap timeout.

Parameters:
XLEN, 32, datapath/PC width
DEPTH, 128, golden trace entries (power of 2)
DMEM_AW, 8, data-memory word-address width
CNT_W, 16, error/commit counter width
TIMEOUT, 1024, max cycles between commits while running

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
gld_wr_en  in  1  golden trace write strobe
gld_wr_addr  in  log2(DEPTH)  golden entry index
gld_wr_data  in  ENTRY_W  packed entry {pc, rd_we, rd[4:0], rd_data, mem_we, mem_addr, mem_data}, pc at MSB; ENTRY_W = 3*XLEN+7+DMEM_AW
trace_len  in  log2(DEPTH)+1  number of entries to check (1..DEPTH)
start  in  1  begin check run
commit_valid  in  1  one instruction retired this cycle
commit_pc  in  XLEN  retired PC
commit_rd_we  in  1  register write performed
commit_rd  in  5  destination register
commit_rd_data  in  XLEN  written value
commit_mem_we  in  1  store performed
commit_mem_addr  in  DMEM_AW  store word address
commit_mem_data  in  XLEN  stored word
busy  out  1  state RUN
done  out  1  state DONE
pass  out  1  done and err_count==0 and !timeout
timeout  out  1  sticky, run ended by commit gap
err_count  out  CNT_W  mismatching commits, saturating
commit_idx  out  log2(DEPTH)+1  commits checked this run
first_err_valid  out  1  first_err_* captured
first_err_idx  out  log2(DEPTH)  entry index of first mismatch
first_err_mask  out  3  {pc, rd, mem} fields that failed at first mismatch

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; gap counter 0. Golden memory is NOT reset.
- FSM IDLE -> RUN on start; DONE -> RUN on start (re-arm). In RUN, start is ignored.
- Entry to RUN clears err_count, commit_idx, first_err_*, timeout and the gap counter.
- RUN -> DONE on a commit with commit_idx == trace_len-1, or when the gap counter reaches TIMEOUT (timeout=1).
- DONE holds all results until start or rst.
- trace_len=0 is treated as 1.
- Golden writes: accepted in IDLE/DONE; ignored in RUN.
- Compare: on commit_valid in RUN, entry G = golden[commit_idx], read combinationally. Results register at the same clock edge, so outputs are visible one cycle after the commit.
- pc field fails if commit_pc != G.pc.
- rd field: an rd write to x0 is treated as no write on both DUT and golden sides. Fails if effective rd_we differs, or if both write and (rd or rd_data) differ.
- mem field: fails if mem_we differs, or if both store and (addr or data) differ.
- A commit with any failing field increments err_count once, saturating at 2^CNT_W-1.
- The first failing commit latches first_err_idx/first_err_mask and sets first_err_valid; later mismatches do not overwrite them.
- commit_idx increments on every RUN commit.
- Gap counter: reset to 0 on each RUN commit, else increments. Timeout is checked on the same edge and takes effect only if no commit occurs that cycle.
- Commit and timeout in the same cycle: the commit wins and is checked.
- commit_valid outside RUN: ignored, no counter changes.
- rst asserted mid-RUN: immediate return to IDLE; partial results are lost.

Test Plan:
1. Load 4-entry trace (pc 0,4,8,C; entry 1 writes x5=0x2A), trace_len=4, start, feed matching commits -> done=1, pass=1, err_count=0, commit_idx=4 one cycle after 4th commit.
2. Same trace, commit 2 pc=0x10 and rd_data=0x2B on commit 1 -> err_count=2, first_err_idx=1, first_err_mask=3'b010, pass=0.
3. Golden write x0=0x5 vs DUT rd_we=0 -> no mismatch. Golden store addr 3 data 0xFF vs DUT addr 4 -> mask 3'b001.
4. TIMEOUT=8, start, one commit then idle -> done=1, timeout=1, pass=0 exactly 8 cycles after last commit. Commit on that 8th cycle -> no timeout.
5. CNT_W=2, 5 mismatching commits -> err_count saturates at 3.
6. rst pulse mid-RUN after 2 commits -> all outputs 0 immediately. Restart without reloading golden -> full pass, confirming golden memory survived reset.

Source files
------------

// File: rtl/commit_trace_checker.sv
// Lockstep commit checker: compares each retired instruction against a preloaded
// golden commit trace and reports error counts, first-failure info and commit-gap timeout.
module commit_trace_checker #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned DMEM_AW = 8,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 1024,
    localparam int unsigned AW      = $clog2(DEPTH),
    localparam int unsigned ENTRY_W = 3 * XLEN + 7 + DMEM_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               gld_wr_en,
    input  logic [AW-1:0]      gld_wr_addr,
    input  logic [ENTRY_W-1:0] gld_wr_data,
    input  logic [AW:0]        trace_len,
    input  logic               start,
    input  logic               commit_valid,
    input  logic [XLEN-1:0]    commit_pc,
    input  logic               commit_rd_we,
    input  logic [4:0]         commit_rd,
    input  logic [XLEN-1:0]    commit_rd_data,
    input  logic               commit_mem_we,
    input  logic [DMEM_AW-1:0] commit_mem_addr,
    input  logic [XLEN-1:0]    commit_mem_data,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               timeout,
    output logic [CNT_W-1:0]   err_count,
    output logic [AW:0]        commit_idx,
    output logic               first_err_valid,
    output logic [AW-1:0]      first_err_idx,
    output logic [2:0]         first_err_mask
);

    localparam int unsigned GAP_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic               rd_we;
        logic [4:0]         rd;
        logic [XLEN-1:0]    rd_data;
        logic               mem_we;
        logic [DMEM_AW-1:0] mem_addr;
        logic [XLEN-1:0]    mem_data;
    } entry_t;

    entry_t gld_mem_q [DEPTH];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [AW:0]      commit_idx_q, commit_idx_d;
    logic             first_err_valid_q, first_err_valid_d;
    logic [AW-1:0]    first_err_idx_q, first_err_idx_d;
    logic [2:0]       first_err_mask_q, first_err_mask_d;
    logic             timeout_q, timeout_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    entry_t      gld;
    logic        gld_rd_eff, dut_rd_eff;
    logic        pc_fail, rd_fail, mem_fail;
    logic [AW:0] eff_len;
    logic        last_commit;

    // Golden storage is intentionally not reset so a trace survives rst pulses.
    always_ff @(posedge clk) begin
        if (gld_wr_en && state_q != S_RUN) begin
            gld_mem_q[gld_wr_addr] <= entry_t'(gld_wr_data);
        end
    end

    always_comb begin
        gld        = gld_mem_q[commit_idx_q[AW-1:0]];
        // A write to x0 architecturally does nothing, so it is not a write on either side.
        gld_rd_eff = gld.rd_we && (gld.rd != 5'd0);
        dut_rd_eff = commit_rd_we && (commit_rd != 5'd0);
        pc_fail    = (commit_pc != gld.pc);
        rd_fail    = (gld_rd_eff != dut_rd_eff) ||
                     (gld_rd_eff && dut_rd_eff &&
                      ((commit_rd != gld.rd) || (commit_rd_data != gld.rd_data)));
        mem_fail   = (gld.mem_we != commit_mem_we) ||
                     (gld.mem_we && commit_mem_we &&
                      ((commit_mem_addr != gld.mem_addr) || (commit_mem_data != gld.mem_data)));
        eff_len     = (trace_len == '0) ? (AW+1)'(1) : trace_len;
        last_commit = (commit_idx_q == (eff_len - (AW+1)'(1)));
    end

    always_comb begin
        state_d           = state_q;
        err_count_d       = err_count_q;
        commit_idx_d      = commit_idx_q;
        first_err_valid_d = first_err_valid_q;
        first_err_idx_d   = first_err_idx_q;
        first_err_mask_d  = first_err_mask_q;
        timeout_d         = timeout_q;
        gap_d             = gap_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d           = S_RUN;
                    err_count_d       = '0;
                    commit_idx_d      = '0;
                    first_err_valid_d = 1'b0;
                    first_err_idx_d   = '0;
                    first_err_mask_d  = '0;
                    timeout_d         = 1'b0;
                    gap_d             = '0;
                end
            end
            S_RUN: begin
                // A commit always takes priority over an expiring gap counter.
                if (commit_valid) begin
                    gap_d        = '0;
                    commit_idx_d = commit_idx_q + (AW+1)'(1);
                    if (pc_fail || rd_fail || mem_fail) begin
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + CNT_W'(1);
                        end
                        if (!first_err_valid_q) begin
                            first_err_valid_d = 1'b1;
                            first_err_idx_d   = commit_idx_q[AW-1:0];
                            first_err_mask_d  = {pc_fail, rd_fail, mem_fail};
                        end
                    end
                    if (last_commit) begin
                        state_d = S_DONE;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                    if (gap_q == GAP_W'(TIMEOUT - 1)) begin
                        state_d   = S_DONE;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= S_IDLE;
            err_count_q       <= '0;
            commit_idx_q      <= '0;
            first_err_valid_q <= 1'b0;
            first_err_idx_q   <= '0;
            first_err_mask_q  <= '0;
            timeout_q         <= 1'b0;
            gap_q             <= '0;
        end else begin
            state_q           <= state_d;
            err_count_q       <= err_count_d;
            commit_idx_q      <= commit_idx_d;
            first_err_valid_q <= first_err_valid_d;
            first_err_idx_q   <= first_err_idx_d;
            first_err_mask_q  <= first_err_mask_d;
            timeout_q         <= timeout_d;
            gap_q             <= gap_d;
        end
    end

    assign busy            = (state_q == S_RUN);
    assign done            = (state_q == S_DONE);
    assign pass            = done && (err_count_q == '0) && !timeout_q;
    assign timeout         = timeout_q;
    assign err_count       = err_count_q;
    assign commit_idx      = commit_idx_q;
    assign first_err_valid = first_err_valid_q;
    assign first_err_idx   = first_err_idx_q;
    assign first_err_mask  = first_err_mask_q;

endmodule
